// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - instruction-memory request/response bundle between fetch unit and imem
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - fetch PC, single-outstanding imem request and IF/ID register with delay-slot redirects
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  pc_fetch_if.master  imem,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        addr_err
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] fpc;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic        redir_pend;
  logic [31:0] redir_tgt;
  logic [31:0] redirect_aligned;
  logic [31:0] next_target;
  logic        accept;
  logic        load_if;
  logic        load_buf;
  logic        unload_buf;
  logic        bubble;

  assign imem.imem_req  = (state == ISSUE) && !rst;
  assign imem.imem_addr = {fpc[31:2], 2'b00};

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // A redirect arriving this cycle beats an older pending one; the delay slot
  // is preserved because only the request after the current one is affected.
  always_comb begin
    next_target = fpc + PC_STEP;
    if (redirect_valid) begin
      next_target = redirect_aligned;
    end else if (redir_pend) begin
      next_target = redir_tgt;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load_if    = 1'b0;
    load_buf   = 1'b0;
    unload_buf = 1'b0;
    bubble     = 1'b0;
    unique case (state)
      ISSUE: begin
        state_next = WAIT;
        bubble     = !stall;
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          accept = 1'b1;
          if (stall) begin
            load_buf   = 1'b1;
            state_next = HOLD;
          end else begin
            load_if    = 1'b1;
            state_next = ISSUE;
          end
        end else begin
          bubble = !stall;
        end
      end
      HOLD: begin
        if (!stall) begin
          unload_buf = 1'b1;
          state_next = ISSUE;
        end
      end
      default: state_next = ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ISSUE;
      fpc        <= RESET_PC;
      redir_pend <= 1'b0;
      redir_tgt  <= 32'h0;
      addr_err   <= 1'b0;
      if_valid   <= 1'b0;
      if_pc      <= 32'h0;
      if_instr   <= 32'h0;
    end else begin
      state <= state_next;

      if (accept) begin
        fpc        <= next_target;
        redir_pend <= 1'b0;
      end else if (redirect_valid) begin
        redir_pend <= 1'b1;
        redir_tgt  <= redirect_aligned;
      end

      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
        addr_err <= 1'b1;
      end

      if (load_if) begin
        if_valid <= 1'b1;
        if_pc    <= fpc;
        if_instr <= imem.imem_rdata;
      end else if (unload_buf) begin
        if_valid <= 1'b1;
        if_pc    <= buf_pc;
        if_instr <= buf_instr;
      end else if (bubble) begin
        if_valid <= 1'b0;
      end
    end
  end

  // Skid buffer needs no reset: it is only read in HOLD, after being written.
  always_ff @(posedge clk) begin
    if (load_buf) begin
      buf_pc    <= fpc;
      buf_instr <= imem.imem_rdata;
    end
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Fetch-stage PC and instruction-request unit. It owns the fetch PC, issues one instruction-memory request at a time, and loads the IF/ID register.
- It accepts redirect targets from the ID-stage branch unit (the newPC/target produced for j/jal/jr/beq/bne/blez/bgtz/bltz/bgez) and honours MIPS single delay-slot semantics.
- It sits between the hazard unit (stall), the instruction memory and the ID stage.

Parameters:
RESET_PC, 32'h0000_3000, fetch address of the first request after reset
PC_STEP, 4, sequential increment in bytes

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold IF/ID register contents
redirect_valid  input  1  one-cycle strobe: taken branch/jump resolved in ID
redirect_pc  input  32  branch/jump target
imem_req  output  1  request strobe, high exactly one cycle per request
imem_addr  output  32  word-aligned fetch address, valid while imem_req=1
imem_rvalid  input  1  response strobe, at least 1 cycle after imem_req
imem_rdata  input  32  instruction word, valid with imem_rvalid
if_valid  output  1  IF/ID register holds a real instruction
if_pc  output  32  PC of the instruction in IF/ID
if_instr  output  32  instruction in IF/ID
addr_err  output  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- Registers:
  - fpc: address of the request being issued or outstanding.
  - state: ISSUE, WAIT or HOLD.
  - buf_instr / buf_pc: one-entry skid buffer.
  - redir_pend / redir_tgt: pending redirect.
- Reset values (reset applied, takes effect next edge):
  - fpc=RESET_PC, state=ISSUE, redir_pend=0, addr_err=0.
  - if_valid=0, if_pc=0, if_instr=0.
  - imem_req=0 during the reset cycle.
- ISSUE:
  - imem_req=1, imem_addr=fpc (combinational from fpc, bits[1:0] forced 00).
  - Next state is WAIT, unconditionally.
  - imem_rvalid seen in ISSUE is stale (e.g. a response to a request issued before reset) and is ignored.
- WAIT, imem_rvalid=1 and stall=0:
  - if_valid<=1, if_pc<=fpc, if_instr<=imem_rdata.
  - fpc<=next_target; state<=ISSUE.
- WAIT, imem_rvalid=1 and stall=1:
  - buf_pc<=fpc, buf_instr<=imem_rdata.
  - fpc<=next_target; state<=HOLD.
  - IF/ID is unchanged.
- WAIT, imem_rvalid=0:
  - stall=0: if_valid<=0 (bubble); if_pc and if_instr hold.
  - stall=1: everything holds.
- HOLD:
  - No request is issued; imem_rvalid is ignored.
  - When stall=0: if_valid<=1, if_pc<=buf_pc, if_instr<=buf_instr; state<=ISSUE.
- next_target, priority order:
  1. redirect_valid this cycle → redirect_pc.
  2. Else redir_pend → redir_tgt.
  3. Else fpc+PC_STEP (32-bit wrap, 32'hFFFF_FFFC+4=0).
  - redir_pend clears on the cycle it is consumed.
- Redirect capture:
  - A redirect_valid not consumed the same cycle sets redir_pend=1 and redir_tgt=redirect_pc.
  - A second redirect while pending overwrites the first (last wins).
  - Both cases apply in every state.
- Delay slot:
  - Branch at P enters IF/ID in cycle t; the request for P+4 issues at t+1.
  - The redirect arrives at t+1 or later and never alters a request already issued, so P+4 always executes.
  - The request after that uses the target.
- Misaligned target: redirect_pc[1:0]!=0 → target used with bits[1:0] cleared, and addr_err<=1 (sticky until rst).
- Throughput: one instruction per 2 cycles with 1-cycle memory latency (ISSUE+WAIT); the design is non-pipelined.
- Reset mid-operation:
  - Outstanding request is abandoned and the pending redirect is dropped.
  - The first post-reset response accepted is the one for RESET_PC.
- stall and redirect_valid in the same cycle: the redirect is still captured; stall affects only the IF/ID update.

Test Plan:
- Reset, 1-cycle-latency memory returning addr-as-data, no stall → imem_addr sequence 3000,3004,3008; if_pc follows with if_instr=if_pc; if_valid pulses 1,0 alternating.
- Branch at 3008 delivered; redirect_valid=1, redirect_pc=3100 pulsed during the 300C ISSUE cycle → requests 300C then 3100; if_pc sequence 3008,300C,3100.
- stall held 3 cycles while the 3004 response arrives → IF/ID keeps 3000 and no new imem_req; after release if_pc=3004, next request 3008.
- Redirect to 0000_0402 → target 0000_0400 issued and addr_err=1 thereafter; addr_err stays 1 across later redirects until rst.
- rst asserted in WAIT with the 300C request outstanding, stale imem_rvalid arriving next cycle → ignored; next imem_addr=3000 and if_valid stays 0 until the 3000 response.
- fpc=FFFF_FFFC, no redirect → next imem_addr=0000_0000; two redirects 4000 then 5000 while in WAIT → next request 5000.
